// File: rtl/operand_read.sv
// Decode/operand-read stage: splits the instruction, reads the register file,
// bypasses same-cycle writeback and latches the decode/execute register.
module operand_read #(
    parameter int          PC_W    = 12,
    parameter logic [4:0]  OP_ALU  = 5'b00000,
    parameter logic [4:0]  OP_ADDI = 5'b00101,
    parameter logic [4:0]  OP_SW   = 5'b01000,
    parameter logic [4:0]  OP_LW   = 5'b00111
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_in,
    input  logic [31:0]     insn_in,
    input  logic            nop_in,
    input  logic            stall,
    input  logic            flush,
    output logic [4:0]      ctrl_readRegA,
    output logic [4:0]      ctrl_readRegB,
    input  logic [31:0]     data_readRegA,
    input  logic [31:0]     data_readRegB,
    input  logic            ctrl_writeEnable,
    input  logic [4:0]      ctrl_writeReg,
    input  logic [31:0]     data_writeReg,
    output logic [PC_W-1:0] pc_out,
    output logic [4:0]      opcode_out,
    output logic [4:0]      rd_out,
    output logic [4:0]      shamt_out,
    output logic [4:0]      aluop_out,
    output logic [31:0]     imm_out,
    output logic [26:0]     target_out,
    output logic [31:0]     valA_out,
    output logic [31:0]     valB_out,
    output logic            we_out,
    output logic            nop_out
);

    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  aluop;
    logic [31:0] imm;
    logic [26:0] target;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        we_dec;
    logic [4:0]  srcA_q;
    logic [4:0]  srcB_q;
    logic        refresh_a;
    logic        refresh_b;

    assign opcode = insn_in[31:27];
    assign rd     = insn_in[26:22];
    assign rs     = insn_in[21:17];
    assign rt     = insn_in[16:12];
    assign shamt  = insn_in[11:7];
    assign aluop  = insn_in[6:2];
    assign imm    = {{15{insn_in[16]}}, insn_in[16:0]};
    assign target = insn_in[26:0];

    // Stores read their data register through port B instead of rt.
    assign ctrl_readRegA = rs;
    assign ctrl_readRegB = (opcode == OP_SW) ? rd : rt;

    // Operand select: r0 forced to zero, else writeback bypass, else regfile.
    always_comb begin
        op_a = data_readRegA;
        op_b = data_readRegB;
        if (ctrl_readRegA == 5'd0)
            op_a = 32'h0;
        else if (ctrl_writeEnable && ctrl_writeReg == ctrl_readRegA)
            op_a = data_writeReg;
        if (ctrl_readRegB == 5'd0)
            op_b = 32'h0;
        else if (ctrl_writeEnable && ctrl_writeReg == ctrl_readRegB)
            op_b = data_writeReg;
    end

    // Register-writing opcodes; a write to r0 is dropped here.
    always_comb begin
        we_dec = 1'b0;
        if ((opcode == OP_ALU || opcode == OP_ADDI || opcode == OP_LW)
            && rd != 5'd0)
            we_dec = 1'b1;
    end

    // While stalled, the held operands must track writebacks to their sources.
    assign refresh_a = ctrl_writeEnable && ctrl_writeReg != 5'd0
                       && !nop_out && ctrl_writeReg == srcA_q;
    assign refresh_b = ctrl_writeEnable && ctrl_writeReg != 5'd0
                       && !nop_out && ctrl_writeReg == srcB_q;

    // Decode/execute pipeline register: flush beats stall beats load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_out     <= '0;
            opcode_out <= '0;
            rd_out     <= '0;
            shamt_out  <= '0;
            aluop_out  <= '0;
            imm_out    <= '0;
            target_out <= '0;
            valA_out   <= '0;
            valB_out   <= '0;
            we_out     <= 1'b0;
            nop_out    <= 1'b1;
            srcA_q     <= '0;
            srcB_q     <= '0;
        end else if (flush) begin
            pc_out     <= pc_in;
            opcode_out <= opcode;
            rd_out     <= rd;
            shamt_out  <= shamt;
            aluop_out  <= aluop;
            imm_out    <= imm;
            target_out <= target;
            valA_out   <= '0;
            valB_out   <= '0;
            we_out     <= 1'b0;
            nop_out    <= 1'b1;
            srcA_q     <= ctrl_readRegA;
            srcB_q     <= ctrl_readRegB;
        end else if (stall) begin
            if (refresh_a)
                valA_out <= data_writeReg;
            if (refresh_b)
                valB_out <= data_writeReg;
        end else begin
            pc_out     <= pc_in;
            opcode_out <= opcode;
            rd_out     <= rd;
            shamt_out  <= shamt;
            aluop_out  <= aluop;
            imm_out    <= imm;
            target_out <= target;
            valA_out   <= nop_in ? 32'h0 : op_a;
            valB_out   <= nop_in ? 32'h0 : op_b;
            we_out     <= we_dec & ~nop_in;
            nop_out    <= nop_in;
            srcA_q     <= ctrl_readRegA;
            srcB_q     <= ctrl_readRegB;
        end
    end

endmodule

// File: tb/tb_operand_read.sv
// Bench for operand_read: directed instructions, expected pipeline-register
// contents queued per edge and checked by an independent monitor.
module tb_operand_read;

    typedef struct {
        logic [11:0] pc;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [4:0]  al;
        logic [31:0] imm;
        logic [26:0] tgt;
        logic [31:0] va;
        logic [31:0] vb;
        logic        we;
        logic        nop;
        logic        full;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] pc_in = '0;
    logic [31:0] insn_in = '0;
    logic        nop_in = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA = '0;
    logic [31:0] data_readRegB = '0;
    logic        ctrl_writeEnable = 1'b0;
    logic [4:0]  ctrl_writeReg = '0;
    logic [31:0] data_writeReg = '0;
    logic [11:0] pc_out;
    logic [4:0]  opcode_out;
    logic [4:0]  rd_out;
    logic [4:0]  shamt_out;
    logic [4:0]  aluop_out;
    logic [31:0] imm_out;
    logic [26:0] target_out;
    logic [31:0] valA_out;
    logic [31:0] valB_out;
    logic        we_out;
    logic        nop_out;

    int checks = 0;
    int errors = 0;
    exp_t  sb[$];
    string sb_nm[$];

    operand_read dut (
        .clock(clock), .reset(reset), .pc_in(pc_in), .insn_in(insn_in),
        .nop_in(nop_in), .stall(stall), .flush(flush),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .pc_out(pc_out),
        .opcode_out(opcode_out), .rd_out(rd_out), .shamt_out(shamt_out),
        .aluop_out(aluop_out), .imm_out(imm_out), .target_out(target_out),
        .valA_out(valA_out), .valB_out(valB_out), .we_out(we_out),
        .nop_out(nop_out)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(
        logic [11:0] pc, logic [4:0] op, logic [4:0] rd, logic [4:0] sh,
        logic [4:0] al, logic [31:0] imm, logic [26:0] tgt,
        logic [31:0] va, logic [31:0] vb, logic we, logic nop, logic full);
        exp_t e;
        e.pc = pc; e.op = op; e.rd = rd; e.sh = sh; e.al = al;
        e.imm = imm; e.tgt = tgt; e.va = va; e.vb = vb;
        e.we = we; e.nop = nop; e.full = full;
        return e;
    endfunction

    // Monitor: each queued expectation is compared at the next falling edge.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            automatic exp_t  e  = sb.pop_front();
            automatic string nm = sb_nm.pop_front();
            automatic logic  bad;
            bad = (nop_out !== e.nop) || (we_out !== e.we)
                  || (valA_out !== e.va) || (valB_out !== e.vb);
            if (e.full)
                bad = bad || (pc_out !== e.pc) || (opcode_out !== e.op)
                      || (rd_out !== e.rd) || (shamt_out !== e.sh)
                      || (aluop_out !== e.al) || (imm_out !== e.imm)
                      || (target_out !== e.tgt);
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s: got pc=%h op=%h rd=%h sh=%h al=%h imm=%h tgt=%h va=%h vb=%h we=%b nop=%b; want pc=%h op=%h rd=%h sh=%h al=%h imm=%h tgt=%h va=%h vb=%h we=%b nop=%b",
                    nm, pc_out, opcode_out, rd_out, shamt_out, aluop_out,
                    imm_out, target_out, valA_out, valB_out, we_out, nop_out,
                    e.pc, e.op, e.rd, e.sh, e.al, e.imm, e.tgt, e.va, e.vb,
                    e.we, e.nop);
            end
        end
    end

    task automatic tick(input exp_t e, input string nm);
        @(posedge clock);
        #1;
        sb.push_back(e);
        sb_nm.push_back(nm);
    endtask

    task automatic drive(input logic [11:0] pc, input logic [31:0] insn,
                         input logic [31:0] ra, input logic [31:0] rb,
                         input logic nop);
        pc_in = pc; insn_in = insn;
        data_readRegA = ra; data_readRegB = rb; nop_in = nop;
    endtask

    task automatic wb(input logic en, input logic [4:0] r,
                      input logic [31:0] d);
        ctrl_writeEnable = en; ctrl_writeReg = r; data_writeReg = d;
    endtask

    task automatic chk_addr(input logic [4:0] a, input logic [4:0] b,
                            input string nm);
        #1;
        checks++;
        if (ctrl_readRegA !== a || ctrl_readRegB !== b) begin
            errors++;
            $display("FAIL %s: got A=%0d B=%0d want A=%0d B=%0d",
                     nm, ctrl_readRegA, ctrl_readRegB, a, b);
        end
    endtask

    // Assert reset between edges; outputs must clear before any clock edge.
    task automatic async_reset(input string nm);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        sb_nm.push_back(nm);
        @(negedge clock);
        #2;
        reset = 1'b1;
    endtask

    exp_t g;

    initial begin
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        sb_nm.push_back("reset_init");
        #6;
        reset = 1'b1;

        // ALU rd2 rs1 rt3
        drive(12'h004, 32'h00823000, 32'h11, 32'h33, 0);
        chk_addr(5'd1, 5'd3, "addr_alu");
        tick(mk(12'h004, 0, 2, 0, 0, 32'h3000, 27'h0823000,
                32'h11, 32'h33, 1, 0, 1), "alu_basic");

        async_reset("reset_midrun");

        // addi $3,$1,-5
        drive(12'h010, 32'h28C3FFFB, 32'd10, 32'h77, 0);
        tick(mk(12'h010, 5'd5, 3, 31, 30, 32'hFFFFFFFB, 27'h0C3FFFB,
                32'd10, 32'h77, 1, 0, 1), "addi_neg_imm");

        // ALU rd7 rs4 rt5 with bypass on B
        drive(12'h014, 32'h01C85000, 32'h44, 32'd7, 0);
        wb(1, 5'd5, 32'hCAFE);
        chk_addr(5'd4, 5'd5, "addr_bypass");
        tick(mk(12'h014, 0, 7, 0, 0, 32'h5000, 27'h1C85000,
                32'h44, 32'hCAFE, 1, 0, 1), "bypass_b");

        // sw rd6 rs2: port B reads rd
        drive(12'h018, 32'h41840000, 32'h22, 32'h66, 0);
        wb(0, 0, 0);
        chk_addr(5'd2, 5'd6, "addr_sw");
        tick(mk(12'h018, 5'd8, 6, 0, 0, 32'h0, 27'h1840000,
                32'h22, 32'h66, 0, 0, 1), "sw_no_we");

        // rs=rt=0 with writeback to r0
        drive(12'h01C, 32'h02400000, 32'hDEAD, 32'hBEEF, 0);
        wb(1, 5'd0, 32'd99);
        tick(mk(12'h01C, 0, 9, 0, 0, 32'h0, 27'h2400000,
                32'h0, 32'h0, 1, 0, 1), "r0_zero");

        // ALU rd10 rs8 rt11, then stall three cycles
        drive(12'h020, 32'h0290B000, 32'h88, 32'hBB, 0);
        wb(0, 0, 0);
        g = mk(12'h020, 0, 10, 0, 0, 32'hB000, 27'h290B000,
               32'h88, 32'hBB, 1, 0, 1);
        tick(g, "alu_pre_stall");
        stall = 1'b1;
        drive(12'h024, 32'h03060088, 32'h99, 32'hAA, 0);
        wb(1, 5'd3, 32'h5555);
        tick(g, "stall_c1_no_refresh");
        wb(1, 5'd8, 32'h1234);
        g.va = 32'h1234;
        tick(g, "stall_c2_refresh");
        wb(0, 0, 0);
        tick(g, "stall_c3_hold");
        stall = 1'b0;
        drive(12'h024, 32'h03060088, 32'h33, 32'hFFFF, 0);
        tick(mk(12'h024, 0, 12, 1, 2, 32'h88, 27'h3060088,
                32'h33, 32'h0, 1, 0, 1), "stall_release");

        // flush overrides stall
        stall = 1'b1; flush = 1'b1;
        drive(12'h028, 32'h28C3FFFB, 32'd10, 32'h77, 0);
        tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "flush_over_stall");
        stall = 1'b0; flush = 1'b0;

        // bubble with valid-looking addi bits
        drive(12'h028, 32'h28C3FFFB, 32'd10, 32'h77, 1);
        tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "nop_in_bubble");

        // lw to r0: no write enable
        drive(12'h02C, 32'h38020000, 32'd5, 32'h1, 0);
        tick(mk(12'h02C, 5'd7, 0, 0, 0, 32'h0, 27'h0020000,
                32'd5, 32'h0, 0, 0, 1), "lw_rd0");

        // both ports read r6, both bypass
        drive(12'h030, 32'h004C6000, 32'd1, 32'd2, 0);
        wb(1, 5'd6, 32'hABCD);
        tick(mk(12'h030, 0, 1, 0, 0, 32'h6000, 27'h04C6000,
                32'hABCD, 32'hABCD, 1, 0, 1), "both_bypass");

        // reset while stalled drops the held instruction
        wb(0, 0, 0);
        stall = 1'b1;
        async_reset("reset_midstall");
        wb(1, 5'd6, 32'h7777);
        tick(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "stall_after_reset");
        stall = 1'b0;
        wb(0, 0, 0);
        drive(12'h034, 32'h19400000, 32'h1, 32'h2, 0);
        tick(mk(12'h034, 5'd3, 5, 0, 0, 32'h0, 27'h1400000,
                32'h0, 32'h0, 0, 0, 1), "unknown_op_no_we");

        repeat (4) @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
